// File: rtl/press_event_controller_pkg.sv
// Shared definitions for the press event controller: FSM state encoding and mode width.
package press_event_controller_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESSED  = 3'd1,
        ST_WAIT_GAP = 3'd2,
        ST_SECOND   = 3'd3,
        ST_LONGHELD = 3'd4
    } state_t;

endpackage

// File: rtl/press_event_controller_press_timer.sv
// Saturating press/gap timer shared by all timed states; flags the long and gap thresholds.
module press_timer #(
    parameter int counterwidth = 8,
    parameter int longtime     = 100,
    parameter int gaptime      = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit_long,
    output logic o_hit_gap
);

    localparam logic [counterwidth-1:0] LONG_LAST = counterwidth'(longtime - 1);
    localparam logic [counterwidth-1:0] GAP_LAST  = counterwidth'(gaptime - 1);
    localparam logic [counterwidth-1:0] CNT_MAX   = '1;
    localparam logic [counterwidth-1:0] CNT_ONE   = counterwidth'(1);

    logic [counterwidth-1:0] r_count;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign o_hit_long = (r_count == LONG_LAST);
    assign o_hit_gap  = (r_count == GAP_LAST);

endmodule

// File: rtl/press_event_controller.sv
// Classifies conditioned button edges into short/double/long presses, a hold level and a mode count.
module press_event_controller
    import press_event_controller_pkg::*;
#(
    parameter int counterwidth = 8,
    parameter int longtime     = 100,
    parameter int gaptime      = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              conditioned,
    input  logic              positiveedge,
    input  logic              negativeedge,
    output logic              short_press,
    output logic              double_press,
    output logic              long_press,
    output logic              hold,
    output logic [MODE_W-1:0] mode,
    output logic              busy
);

    localparam logic [MODE_W-1:0] MODE_ONE = MODE_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_blocked;
    logic              r_short;
    logic              r_double;
    logic              r_long;
    logic              r_hold;
    logic              r_busy;
    logic [MODE_W-1:0] r_mode;

    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_short;
    logic w_double;
    logic w_long;
    logic w_hold_next;
    logic w_timer_clear;
    logic w_timer_enable;
    logic w_hit_long;
    logic w_hit_gap;

    // Coincident rising and falling pulses cancel out for that cycle.
    assign w_rise  = positiveedge & ~negativeedge;
    assign w_fall  = negativeedge & ~positiveedge;
    assign w_start = w_rise & ~r_blocked;

    press_timer #(
        .counterwidth (counterwidth),
        .longtime     (longtime),
        .gaptime      (gaptime)
    ) u_press_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_timer_clear),
        .i_enable   (w_timer_enable),
        .o_hit_long (w_hit_long),
        .o_hit_gap  (w_hit_gap)
    );

    // A button found held while idle (e.g. across reset) must be released before it can start a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blocked <= 1'b0;
        end else if (w_fall) begin
            r_blocked <= 1'b0;
        end else if ((r_state == ST_IDLE) && conditioned && !w_rise) begin
            r_blocked <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_short        = 1'b0;
        w_double       = 1'b0;
        w_long         = 1'b0;
        w_hold_next    = r_hold;
        w_timer_clear  = 1'b0;
        w_timer_enable = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next  = ST_PRESSED;
                    w_timer_clear = 1'b1;
                end
            end
            ST_PRESSED: begin
                w_timer_enable = 1'b1;
                if (w_fall) begin
                    w_state_next  = ST_WAIT_GAP;
                    w_timer_clear = 1'b1;
                end else if (w_hit_long) begin
                    w_state_next = ST_LONGHELD;
                    w_long       = 1'b1;
                    w_hold_next  = 1'b1;
                end
            end
            ST_WAIT_GAP: begin
                w_timer_enable = 1'b1;
                if (w_rise) begin
                    w_state_next  = ST_SECOND;
                    w_timer_clear = 1'b1;
                end else if (w_hit_gap) begin
                    w_state_next = ST_IDLE;
                    w_short      = 1'b1;
                end
            end
            ST_SECOND: begin
                w_timer_enable = 1'b1;
                if (w_fall) begin
                    w_state_next = ST_IDLE;
                    w_double     = 1'b1;
                end else if (w_hit_long) begin
                    // The first short press is dropped once the second one turns long.
                    w_state_next = ST_LONGHELD;
                    w_long       = 1'b1;
                    w_hold_next  = 1'b1;
                end
            end
            ST_LONGHELD: begin
                if (w_fall) begin
                    w_state_next = ST_IDLE;
                    w_hold_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_hold_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_hold   <= 1'b0;
            r_busy   <= 1'b0;
            r_mode   <= '0;
        end else begin
            r_short  <= w_short;
            r_double <= w_double;
            r_long   <= w_long;
            r_hold   <= w_hold_next;
            r_busy   <= (w_state_next != ST_IDLE);
            if (w_short) begin
                r_mode <= r_mode + MODE_ONE;
            end
        end
    end

    assign short_press  = r_short;
    assign double_press = r_double;
    assign long_press   = r_long;
    assign hold         = r_hold;
    assign busy         = r_busy;
    assign mode         = r_mode;

endmodule
